wb_ram_responder: RTL
=====================

Name: wb_ram_responder

Overview:
- Single-port Wishbone-style memory responder: the memory end of the word-addressed, byte-lane-selected bus the CPU memory controller drives.
- Accepts one request at a time, inserts a programmable number of wait states, commits byte-lane writes or reads a full word, then returns a one-cycle ack.
- Sits between the CPU memory controller and on-chip block RAM; also serves as the bench memory model.

Parameters:
- ADDR_WIDTH, 12, word-address bits actually decoded; depth = 2**ADDR_WIDTH 32-bit words.
- WAIT_STATES, 1, extra cycles between request acceptance and ack; legal range 0..15.
- OOR_READ_VALUE, 32'hFFFFFFFF, data returned for out-of-range reads.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_reset  input  1  reset, asynchronous, active-high.
- i_wb_stb  input  1  request strobe; accepted only when high and o_wb_stall is low.
- i_wb_we  input  1  1 = write, 0 = read.
- i_wb_addr  input  32  word address (byte address >> 2).
- i_wb_data  input  32  write data; lanes not selected are don't-care (the initiator fills them with 1s).
- i_wb_sel  input  4  byte-lane enables for writes; bit n covers data[8n+7:8n].
- o_wb_ack  output  1  one-cycle completion pulse.
- o_wb_stall  output  1  busy flag; high while a request is in flight.
- o_wb_data  output  32  read data; valid in the ack cycle and held until the next read completes.

Behaviour:
- Reset (asynchronous, any state): o_wb_ack=0, o_wb_stall=0, o_wb_data=32'hFFFFFFFF, state=S_IDLE, wait counter=0.
  - An in-flight write that has not reached commit is discarded.
  - RAM contents are preserved.
- States: S_IDLE, S_WAIT, S_ACCESS, S_ACK.
- S_IDLE:
  - o_wb_ack=0, o_wb_stall=0.
  - If i_wb_stb is high: latch addr, we, data and sel; set o_wb_stall=1; load counter with WAIT_STATES.
  - Next state is S_WAIT if WAIT_STATES>0, else S_ACCESS.
- S_WAIT: decrement the counter; move to S_ACCESS when the counter reaches 1. Stall stays high.
- S_ACCESS:
  - Write: each lane with sel[n]=1 writes RAM[addr] byte n; other bytes unchanged.
  - Read: RAM[addr] is registered into o_wb_data.
  - Set o_wb_ack=1; next state S_ACK.
- S_ACK:
  - o_wb_ack=0 and o_wb_stall=0 on the exiting edge; next state S_IDLE.
  - The first cycle a new stb can be accepted is the cycle after ack.
- Latency, with the stb-accept cycle = cycle 0:
  - o_wb_stall is high in cycles 1..WAIT_STATES+2.
  - o_wb_ack is high only in cycle WAIT_STATES+2.
  - o_wb_stall is low from cycle WAIT_STATES+3.
- Stb while stall is high is ignored (neither latched nor queued). Stb held high across a request is treated as a new request on the first non-stalled cycle.
- Out of range (i_wb_addr[31:ADDR_WIDTH] != 0):
  - Writes are dropped; reads return OOR_READ_VALUE.
  - Ack timing is identical to in-range accesses.
- Write with sel=4'b0000: no RAM change, normal ack. Reads ignore sel and always return the full word.
- o_wb_data is unchanged by write transactions.
- i_wb_data, i_wb_sel and i_wb_we are sampled only at acceptance; later changes have no effect.

Decomposition:
- Shared package: state encodings S_IDLE..S_ACK, WAIT_STATES bound, default OOR value.
- Sub-module wb_ram_bytelane: 2**ADDR_WIDTH x 32 array with 4-bit byte write-enable and registered read port. It has no reset and is inferable as block RAM.
- The responder FSM and wait counter stay in wb_ram_responder.

Test Plan:
- Write addr 0x10, data 32'hDEADBEEF, sel 4'b1111, WAIT_STATES=1 -> ack in cycle 3 only; stall high in cycles 1-3. Then read 0x10 -> o_wb_data=32'hDEADBEEF in its ack cycle.
- Byte-lane write: preload word 0x20=32'h11223344, write sel 4'b0100 with data 32'hFFAAFFFF -> read returns 32'h11AA3344. Repeat with sel 4'b1000 then 4'b0001 for the split-halfword pattern across words 0x20/0x21.
- Back-to-back with stb held high through stall -> exactly one access per ack; the second request is accepted the cycle after ack; no duplicate write.
- Out of range: read 0x0000_1000 with ADDR_WIDTH=12 -> ack with 32'hFFFFFFFF. Write to the same address, then read word 0x000 -> word 0x000 unchanged.
- Assert i_reset asynchronously in S_WAIT during a write to 0x30 -> ack and stall drop immediately, no ack follows, and word 0x30 keeps its old value.
- WAIT_STATES=0 and WAIT_STATES=15 builds -> ack in cycle 2 and cycle 17 respectively; o_wb_ack is never high for two consecutive cycles.

Source files
------------

// File: rtl/wb_ram_responder_pkg.sv
// Shared definitions for the Wishbone RAM responder: FSM encoding and build-time limits.
package wb_ram_responder_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_ACK    = 2'd3
    } state_t;

    localparam int unsigned MAX_WAIT_STATES   = 15;
    localparam int unsigned WAIT_CNT_WIDTH    = 4;
    localparam logic [31:0] DEFAULT_OOR_VALUE = 32'hFFFF_FFFF;

endpackage

// File: rtl/wb_ram_bytelane.sv
// Single-port 32-bit RAM with per-byte write enables and a registered read port.
module wb_ram_bytelane #(
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic                  i_clk,
    input  logic [3:0]            i_we,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [31:0]           i_wdata,
    output logic [31:0]           o_rdata
);

    logic [31:0] mem [0:(1 << ADDR_WIDTH) - 1];

    // No reset so synthesis can map this onto block RAM.
    always_ff @(posedge i_clk) begin
        for (int n = 0; n < 4; n++) begin
            if (i_we[n]) begin
                mem[i_addr][8*n +: 8] <= i_wdata[8*n +: 8];
            end
        end
        o_rdata <= mem[i_addr];
    end

endmodule

// File: rtl/wb_ram_responder.sv
// Wishbone-style memory responder: one request at a time, programmable wait states,
// byte-lane writes, full-word reads and a single-cycle ack.
module wb_ram_responder
    import wb_ram_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 12,
    parameter int unsigned WAIT_STATES    = 1,
    parameter logic [31:0] OOR_READ_VALUE = DEFAULT_OOR_VALUE
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [31:0] i_wb_addr,
    input  logic [31:0] i_wb_data,
    input  logic [3:0]  i_wb_sel,
    output logic        o_wb_ack,
    output logic        o_wb_stall,
    output logic [31:0] o_wb_data
);

    localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_LOAD = WAIT_CNT_WIDTH'(WAIT_STATES);

    state_t                    state;
    logic [WAIT_CNT_WIDTH-1:0] wait_cnt;
    logic [ADDR_WIDTH-1:0]     addr_q;
    logic [31:0]               data_q;
    logic [3:0]                sel_q;
    logic                      we_q;
    logic                      oor_q;

    logic                      in_range;
    logic [ADDR_WIDTH-1:0]     ram_addr;
    logic [3:0]                ram_we;
    logic [31:0]               ram_rdata;

    assign in_range = (i_wb_addr >> ADDR_WIDTH) == 32'd0;

    // While idle the RAM reads the incoming address so the word is ready by S_ACCESS,
    // even with zero wait states.
    assign ram_addr = (state == S_IDLE) ? i_wb_addr[ADDR_WIDTH-1:0] : addr_q;
    assign ram_we   = (state == S_ACCESS && we_q && !oor_q) ? sel_q : 4'b0000;

    wb_ram_bytelane #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (ram_we),
        .i_addr  (ram_addr),
        .i_wdata (data_q),
        .o_rdata (ram_rdata)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state      <= S_IDLE;
            wait_cnt   <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            sel_q      <= '0;
            we_q       <= 1'b0;
            oor_q      <= 1'b0;
            o_wb_ack   <= 1'b0;
            o_wb_stall <= 1'b0;
            o_wb_data  <= 32'hFFFF_FFFF;
        end else begin
            case (state)
                S_IDLE: begin
                    o_wb_ack <= 1'b0;
                    if (i_wb_stb) begin
                        addr_q     <= i_wb_addr[ADDR_WIDTH-1:0];
                        data_q     <= i_wb_data;
                        sel_q      <= i_wb_sel;
                        we_q       <= i_wb_we;
                        oor_q      <= !in_range;
                        wait_cnt   <= WAIT_LOAD;
                        o_wb_stall <= 1'b1;
                        state      <= (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
                    end
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt - 1'b1;
                    if (wait_cnt <= 1) begin
                        state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (!we_q) begin
                        o_wb_data <= oor_q ? OOR_READ_VALUE : ram_rdata;
                    end
                    o_wb_ack <= 1'b1;
                    state    <= S_ACK;
                end
                S_ACK: begin
                    o_wb_ack   <= 1'b0;
                    o_wb_stall <= 1'b0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
